// File: rtl/dual_wb_stage.sv
// Dual-issue MEM/WB pipeline register with load-data formatting, $0 write suppression,
// same-address write arbitration (slot 2 wins) and a retired-instruction counter.
module dual_wb_stage #(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             s1_valid,
    input  logic             s1_wen,
    input  logic [4:0]       s1_waddr,
    input  logic [31:0]      s1_alu,
    input  logic             s1_load,
    input  logic [2:0]       s1_ltype,
    input  logic [1:0]       s1_boff,
    input  logic [31:0]      s1_mdata,
    input  logic             s2_valid,
    input  logic             s2_wen,
    input  logic [4:0]       s2_waddr,
    input  logic [31:0]      s2_alu,
    input  logic             s2_load,
    input  logic [2:0]       s2_ltype,
    input  logic [1:0]       s2_boff,
    input  logic [31:0]      s2_mdata,
    output logic             reg_w_en_1,
    output logic [4:0]       reg_w_addr_1,
    output logic [31:0]      reg_w_data_1,
    output logic             reg_w_en_2,
    output logic [4:0]       reg_w_addr_2,
    output logic [31:0]      reg_w_data_2,
    output logic [RET_W-1:0] retire_cnt
);
    localparam int DATA_W = 32;

    logic              vld1_p1, vld2_p1;
    logic              wen1_p1, wen2_p1;
    logic [4:0]        waddr1_p1, waddr2_p1;
    logic [DATA_W-1:0] alu1_p1, alu2_p1;
    logic              load1_p1, load2_p1;
    logic [2:0]        ltype1_p1, ltype2_p1;
    logic [1:0]        boff1_p1, boff2_p1;
    logic [DATA_W-1:0] mdata1_p1, mdata2_p1;

    // Little-endian byte/half select; halfword offset uses only boff[1].
    function automatic logic [DATA_W-1:0] fmt_load(input logic [2:0] ltype,
                                                   input logic [1:0] boff,
                                                   input logic [DATA_W-1:0] mdata);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [DATA_W-1:0]  res;
        byte_s = mdata[{boff, 3'b000} +: 8];
        half_s = mdata[{boff[1], 4'b0000} +: 16];
        case (ltype)
            3'b000:  res = {{24{byte_s[7]}}, byte_s};
            3'b100:  res = {24'd0, byte_s};
            3'b001:  res = {{16{half_s[15]}}, half_s};
            3'b101:  res = {16'd0, half_s};
            default: res = mdata;
        endcase
        return res;
    endfunction

    // MEM -> WB boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld1_p1   <= 1'b0;
            vld2_p1   <= 1'b0;
            wen1_p1   <= 1'b0;
            wen2_p1   <= 1'b0;
            waddr1_p1 <= '0;
            waddr2_p1 <= '0;
            alu1_p1   <= '0;
            alu2_p1   <= '0;
            load1_p1  <= 1'b0;
            load2_p1  <= 1'b0;
            ltype1_p1 <= '0;
            ltype2_p1 <= '0;
            boff1_p1  <= '0;
            boff2_p1  <= '0;
            mdata1_p1 <= '0;
            mdata2_p1 <= '0;
        end else if (flush) begin
            vld1_p1 <= 1'b0;
            vld2_p1 <= 1'b0;
        end else if (!stall) begin
            vld1_p1   <= s1_valid;
            vld2_p1   <= s2_valid;
            wen1_p1   <= s1_wen;
            wen2_p1   <= s2_wen;
            waddr1_p1 <= s1_waddr;
            waddr2_p1 <= s2_waddr;
            alu1_p1   <= s1_alu;
            alu2_p1   <= s2_alu;
            load1_p1  <= s1_load;
            load2_p1  <= s2_load;
            ltype1_p1 <= s1_ltype;
            ltype2_p1 <= s2_ltype;
            boff1_p1  <= s1_boff;
            boff2_p1  <= s2_boff;
            mdata1_p1 <= s1_mdata;
            mdata2_p1 <= s2_mdata;
        end
    end

    // Contents leave WB whenever the stage is not stalled, including on flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt <= '0;
        end else if (!stall) begin
            retire_cnt <= retire_cnt + {{(RET_W-1){1'b0}}, vld1_p1}
                                     + {{(RET_W-1){1'b0}}, vld2_p1};
        end
    end

    // WB -> regfile boundary
    always_comb begin
        reg_w_en_2   = vld2_p1 & wen2_p1 & (waddr2_p1 != 5'd0);
        reg_w_en_1   = vld1_p1 & wen1_p1 & (waddr1_p1 != 5'd0)
                     & ~(reg_w_en_2 & (waddr1_p1 == waddr2_p1));
        reg_w_addr_1 = waddr1_p1;
        reg_w_addr_2 = waddr2_p1;
        reg_w_data_1 = load1_p1 ? fmt_load(ltype1_p1, boff1_p1, mdata1_p1) : alu1_p1;
        reg_w_data_2 = load2_p1 ? fmt_load(ltype2_p1, boff2_p1, mdata2_p1) : alu2_p1;
    end

endmodule
